// File: rtl/val_ready_fifo_if.sv
// Ready/valid handshake bundle for val_ready_fifo: upstream beat, downstream head and status.
// slave = the FIFO side, master = the environment driving it.
interface val_ready_fifo_if #(
    parameter int DW    = 8,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          valid_i;
    logic          ready_o;
    logic [DW-1:0] data_in;
    logic          valid_o;
    logic          ready_i;
    logic [DW-1:0] data_out;
    logic [CW-1:0] count_o;
    logic          almost_full_o;

    modport slave (
        input  valid_i, data_in, ready_i,
        output ready_o, valid_o, data_out, count_o, almost_full_o
    );

    modport master (
        output valid_i, data_in, ready_i,
        input  ready_o, valid_o, data_out, count_o, almost_full_o
    );
endinterface

// File: rtl/val_ready_fifo.sv
// DEPTH x DW ready/valid FIFO with occupancy and almost-full status.
// Define VAL_READY_FIFO_BYPASS_EN for a zero-latency pass-through when the FIFO is empty.
module val_ready_fifo #(
    parameter int DW       = 8,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    val_ready_fifo_if.slave   bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] count_q,  count_d;
    logic [DW-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_idx, rd_idx;
    logic          empty, full, bypass, push, pop;

    assign wr_idx = wr_ptr_q[AW-1:0];
    assign rd_idx = rd_ptr_q[AW-1:0];

    // Pointer MSB tells a full ring (same index, laps differ) from an empty one.
    always_comb begin
        // NOTE: every signal written here gets a value on every path, otherwise a latch is inferred.
        empty  = (wr_ptr_q == rd_ptr_q);
        full   = (wr_idx == rd_idx) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        bypass = 1'b0;
`ifdef VAL_READY_FIFO_BYPASS_EN
        bypass = empty && bus.valid_i && bus.ready_i;
`endif
        push   = bus.valid_i && !full && !bypass;
        pop    = !empty && bus.ready_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + PW'(1);
            2'b01:   count_d = count_q - PW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately left out of reset; emptiness comes from the pointers alone.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_idx] <= bus.data_in;
        end
    end

    // ready_o depends only on registered pointers, so ready_i never reaches it combinationally.
    always_comb begin
        bus.ready_o       = !full;
        bus.valid_o       = !empty;
        bus.data_out      = empty ? '0 : mem_q[rd_idx];
`ifdef VAL_READY_FIFO_BYPASS_EN
        if (empty && bus.valid_i) begin
            bus.valid_o  = 1'b1;
            bus.data_out = bus.data_in;
        end
`endif
        bus.count_o       = count_q;
        bus.almost_full_o = (count_q >= PW'(AFULL_TH));
    end
endmodule

// File: tb/tb_val_ready_fifo.sv
// Self-checking bench for val_ready_fifo: directed fill/drain/stream/reset cases plus random
// traffic, all compared each cycle against a queue-based reference model.
module tb_val_ready_fifo;
    localparam int DW       = 8;
    localparam int DEPTH    = 4;
    localparam int AFULL_TH = 3;

    logic clk_i;
    logic rst_i;

    val_ready_fifo_if #(.DW(DW), .DEPTH(DEPTH)) bus ();

    val_ready_fifo #(.DW(DW), .DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mq[$];      // model contents, head at index 0
    logic [DW-1:0] popped[$];  // beats the model saw leave downstream
    bit            acc;        // last step accepted the upstream beat

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    // One clock cycle: compare outputs at the falling edge, then advance the model at the rising edge.
    task automatic step();
        int            sz;
        bit            byp;
        bit            vin, rin, exp_valid, do_pop;
        logic [DW-1:0] din;
        @(negedge clk_i);
        sz  = mq.size();
        vin = bus.valid_i;
        rin = bus.ready_i;
        din = bus.data_in;
        byp = 1'b0;
`ifdef VAL_READY_FIFO_BYPASS_EN
        byp = (sz == 0) && vin;
`endif
        exp_valid = (sz != 0) || byp;
        check("valid_o", bus.valid_o, exp_valid);
        if (exp_valid) check("data_out", bus.data_out, (sz != 0) ? mq[0] : din);
        check("count_o", bus.count_o, sz);
        check("ready_o", bus.ready_o, sz < DEPTH);
        check("almost_full_o", bus.almost_full_o, sz >= AFULL_TH);
        acc    = vin && (sz < DEPTH);
        do_pop = exp_valid && rin;
        @(posedge clk_i);
        if (byp && rin) begin
            popped.push_back(din);
        end else begin
            if (do_pop) popped.push_back(mq.pop_front());
            if (acc)    mq.push_back(din);
        end
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [DW-1:0] fill_vals[5];
        int            first_pop, last_pop, prev_n, nbad, cycles;
        logic [DW-1:0] sent[$];

        fill_vals = '{8'h05, 8'h0A, 8'h0F, 8'h14, 8'h19};

        // Reset state, checked while reset is still asserted.
        rst_i       = 1'b0;
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.data_in = '0;
        #1;
        check("rst_count", bus.count_o, 0);
        check("rst_valid", bus.valid_o, 0);
        check("rst_ready", bus.ready_o, 1);
        check("rst_afull", bus.almost_full_o, 0);
        check("rst_data", bus.data_out, 0);
        #11 rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Two pushes, then async reset mid-stream: outputs clear without a clock edge.
        bus.valid_i = 1'b1; bus.data_in = 8'h11; step();
        bus.data_in = 8'h22; step();
        bus.valid_i = 1'b0;
        check("pre_rst_count", bus.count_o, 2);
        #2 rst_i = 1'b0;
        #1;
        check("async_rst_count", bus.count_o, 0);
        check("async_rst_valid", bus.valid_o, 0);
        check("async_rst_ready", bus.ready_o, 1);
        mq.delete();
        popped.delete();
        @(negedge clk_i) rst_i = 1'b1;
        @(posedge clk_i); #1;

        // Fill to full with downstream stalled; a 5th beat is offered but must not be taken.
        bus.ready_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus.valid_i = 1'b1;
            bus.data_in = fill_vals[i];
            step();
        end
        bus.data_in = fill_vals[4];
        step();
        check("full_no_accept", acc, 0);
        step();
        check("full_ready_low", bus.ready_o, 0);
        check("full_count", bus.count_o, DEPTH);

        // Drain with the held 5th beat still offered; it must leave fifth.
        popped.delete();
        bus.ready_i = 1'b1;
        for (int c = 0; c < 12 && popped.size() < 5; c++) begin
            step();
            if (acc) bus.valid_i = 1'b0;
        end
        check("drain_beats", popped.size(), 5);
        for (int i = 0; i < 5 && i < popped.size(); i++) check("drain_order", popped[i], fill_vals[i]);

        // Back-to-back streaming of 1..10 with both sides always ready.
        popped.delete();
        bus.ready_i = 1'b1;
        bus.valid_i = 1'b1;
        bus.data_in = 8'd1;
        first_pop = -1;
        last_pop  = -1;
        for (int c = 0; c < 30 && popped.size() < 10; c++) begin
            prev_n = popped.size();
            step();
            if (popped.size() != prev_n) begin
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            if (acc) begin
                if (bus.data_in == 8'd10) bus.valid_i = 1'b0;
                else bus.data_in = bus.data_in + 8'd1;
            end
        end
        check("stream_beats", popped.size(), 10);
        for (int i = 0; i < 10 && i < popped.size(); i++) check("stream_order", popped[i], i + 1);
        check("stream_no_gaps", last_pop - first_pop, 9);

        // Random traffic: upstream holds each beat until taken, downstream randomly stalls.
        popped.delete();
        sent.delete();
        bus.valid_i = 1'b0;
        cycles = 0;
        while (popped.size() < 1000 && cycles < 20000) begin
            if (!bus.valid_i && sent.size() < 1000 && $urandom_range(0, 1) == 1) begin
                bus.valid_i = 1'b1;
                bus.data_in = DW'($urandom);
            end
            bus.ready_i = ($urandom_range(0, 1) == 1);
            step();
            if (acc) begin
                sent.push_back(bus.data_in);
                bus.valid_i = 1'b0;
            end
            cycles++;
        end
        check("rand_beats", popped.size(), 1000);
        nbad = 0;
        for (int i = 0; i < popped.size() && i < sent.size(); i++)
            if (popped[i] !== sent[i]) nbad++;
        check("rand_order", nbad, 0);

        // Leave the FIFO empty before the final cases.
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        for (int c = 0; c < 8 && mq.size() != 0; c++) step();
        check("empty_after_rand", bus.count_o, 0);

`ifdef VAL_READY_FIFO_BYPASS_EN
        bus.valid_i = 1'b1;
        bus.data_in = 8'h33;
        bus.ready_i = 1'b1;
        #1;
        check("byp_valid_same_cycle", bus.valid_o, 1);
        check("byp_data_same_cycle", bus.data_out, 8'h33);
        step();
        bus.valid_i = 1'b0;
        check("byp_pass_count", bus.count_o, 0);
        bus.valid_i = 1'b1;
        bus.ready_i = 1'b0;
        #1;
        check("byp_stall_valid", bus.valid_o, 1);
        check("byp_stall_data", bus.data_out, 8'h33);
        step();
        bus.valid_i = 1'b0;
        check("byp_stall_count", bus.count_o, 1);
        check("byp_stall_hold", bus.data_out, 8'h33);
        bus.ready_i = 1'b1;
        step();
        step();
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/val_ready_fifo.md
Name: val_ready_fifo

Overview:
- Parametrised ready/valid buffer, DEPTH entries deep and DW bits wide.
- Upstream side: valid_i / ready_o / data_in. Downstream side: valid_o / ready_i / data_out.
- Sits between any two ready/valid stages to absorb back-pressure and decouple timing; replaces the single-register valid/ready FSM for multi-beat traffic.
- Adds occupancy and almost-full status outputs.

Parameters:
- DW, 8, data width in bits (>=1).
- DEPTH, 4, number of storage entries; power of 2, >=2.
- AFULL_TH, 3, almost_full_o asserts when count_o >= AFULL_TH; range 1..DEPTH.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- valid_i  in  1  upstream beat valid.
- ready_o  out  1  block can accept a beat.
- data_in  in  DW  upstream data.
- valid_o  out  1  head entry valid downstream.
- ready_i  in  1  downstream accepts the head.
- data_out  out  DW  head data.
- count_o  out  $clog2(DEPTH)+1  entries currently stored.
- almost_full_o  out  1  count_o >= AFULL_TH.

Behaviour:
- Reset (rst_i=0, async): wr_ptr=0, rd_ptr=0, count_o=0, ready_o=1 after release, valid_o=0, almost_full_o=0, data_out=0.
  - Memory contents are not reset.
  - Reset mid-transfer discards all stored beats.
- Pointers are $clog2(DEPTH)+1 bits; the MSB distinguishes full from empty. Index = low bits, wrapping naturally DEPTH-1 -> 0.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal AND MSBs differ.
- push = valid_i & ready_o; pop = valid_o & ready_i. Both are evaluated at the same rising edge.
- ready_o = !full. It is registered-state only; there is no combinational path from ready_i to ready_o.
- valid_o = !empty. data_out = mem[rd_ptr index], driven from the registered pointer.
- Latency: a beat pushed at edge N appears on valid_o/data_out in the cycle after edge N (1-cycle latency). Exception: the bypass feature.
- count_o update: +1 on push only, -1 on pop only, unchanged on push&pop or neither.
- Simultaneous push and pop:
  - When neither empty nor full: both pointers advance and count is unchanged.
  - When full: ready_o=0, so only the pop occurs; ready_o rises the next cycle.
  - When empty: only the push occurs.
- Protocol guarantees (verified):
  - Once valid_o=1, it stays 1 and data_out is stable until pop.
  - ready_o may fall only as a result of a push.
- Upstream obligation: valid_i/data_in are held until accepted. Behaviour is undefined otherwise, and no check is made.
- Order is strict FIFO; no beat is dropped or duplicated.
- almost_full_o is combinational from registered count_o.

Optional Feature:
- Macro: VAL_READY_FIFO_BYPASS_EN
- Defined: when empty and valid_i=1, valid_o=valid_i and data_out=data_in combinationally (zero latency).
  - If ready_i=1 in that cycle, the beat passes straight through. Nothing is written, and pointers and count are unchanged.
  - If ready_i=0, the beat is written normally and valid_o stays 1 from storage.
- Not defined: no combinational path from upstream to downstream; 1-cycle minimum latency as above.

Test Plan:
- Reset with rst_i=0 mid-stream after 2 pushes -> count_o=0, valid_o=0, ready_o=1 immediately (async), without waiting for a clock.
- DEPTH=4, ready_i=0, push 0x05,0x0A,0x0F,0x14 -> count_o=4, ready_o=0, almost_full_o=1 from count 3. A 5th beat 0x19 is held by upstream and not accepted.
- Continuing from full, ready_i=1 for 4 cycles -> data_out 0x05,0x0A,0x0F,0x14 in order. ready_o=1 after the first pop, so 0x19 is accepted and emerges 5th. Count never exceeds 4.
- Continuous valid_i=1 and ready_i=1 for 10 beats with data 1..10 (bypass off) -> first valid_o one cycle after first push. Count steady at 1; output sequence 1..10 with no gaps; pointers wrap twice.
- Random valid_i/ready_i (50%), 1000 beats -> scoreboard order match, valid_o/data_out stable while ready_i=0, count_o equals model every cycle.
- VAL_READY_FIFO_BYPASS_EN defined, empty, valid_i=1, data_in=0x33, ready_i=1 -> valid_o=1, data_out=0x33 in the same cycle, count_o stays 0. Repeat with ready_i=0 -> count_o=1 next cycle, data_out holds 0x33.
